// File: rtl/qerv_mem_seq_if.sv
// Request, buffer-control and Wishbone data-bus signals of the qerv load/store sequencer.
// The slave modport is the sequencer; master is the decode/bus side that drives it.
interface qerv_mem_seq_if;
    logic       i_start;
    logic       i_store;
    logic [1:0] i_size;
    logic [1:0] i_lsb;
    logic       o_busy;
    logic       o_init;
    logic       o_en;
    logic       o_byte_valid;
    logic       o_fill;
    logic       o_load;
    logic       o_wb_cyc;
    logic       o_wb_we;
    logic [3:0] o_wb_sel;
    logic       i_wb_ack;
    logic       o_done;
    logic       o_misalign;
    logic       o_bus_err;

    modport master (
        output i_start, i_store, i_size, i_lsb, i_wb_ack,
        input  o_busy, o_init, o_en, o_byte_valid, o_fill, o_load,
        input  o_wb_cyc, o_wb_we, o_wb_sel, o_done, o_misalign, o_bus_err
    );

    modport slave (
        input  i_start, i_store, i_size, i_lsb, i_wb_ack,
        output o_busy, o_init, o_en, o_byte_valid, o_fill, o_load,
        output o_wb_cyc, o_wb_we, o_wb_sel, o_done, o_misalign, o_bus_err
    );
endinterface

// File: rtl/qerv_mem_seq.sv
// Load/store sequencer for the qerv buffer register: init shift (stores), Wishbone
// data-bus cycle with timeout, exec shift (loads), plus misalignment trapping.
module qerv_mem_seq #(
    parameter int unsigned W       = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input logic           i_clk,
    input logic           i_rst,
    qerv_mem_seq_if.slave mem
);
    localparam int unsigned N  = 32 / W;
    localparam int unsigned CW = $clog2(N);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StInit, StBus, StExec} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          store_q, store_d;
    logic [1:0]    size_q, size_d;
    logic [1:0]    lsb_q, lsb_d;
    logic          done_q, done_d;
    logic          misalign_q, misalign_d;
    logic          bus_err_q, bus_err_d;

    logic       is_word, is_half, req_word, req_half, misaligned;
    logic       last_cnt, tmo_hit, in_range;
    logic       in_init, in_bus, in_exec;
    logic [1:0] bi;
    logic [3:0] sel;

    assign is_word  = size_q[1];
    assign is_half  = (size_q == 2'b01);
    assign req_word = mem.i_size[1];
    assign req_half = (mem.i_size == 2'b01);

    assign misaligned = (req_half & mem.i_lsb[0]) | (req_word & (mem.i_lsb != 2'b00));

    // Byte index of the bits currently passing through the register.
    assign bi       = 2'((32'(cnt_q) * W) >> 3);
    assign in_range = is_word | (bi == 2'd0) | (is_half & (bi < 2'd2));
    assign last_cnt = (cnt_q == CW'(N - 1));
    assign tmo_hit  = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = '0;
        store_d    = store_q;
        size_d     = size_q;
        lsb_d      = lsb_q;
        done_d     = 1'b0;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem.i_start) begin
                    if (misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        store_d = mem.i_store;
                        size_d  = mem.i_size;
                        lsb_d   = mem.i_lsb;
                        cnt_d   = '0;
                        state_d = mem.i_store ? StInit : StBus;
                    end
                end
            end
            StInit: begin
                cnt_d = cnt_q + CW'(1);
                if (last_cnt) begin
                    cnt_d   = '0;
                    state_d = StBus;
                end
            end
            StBus: begin
                // An ack coinciding with the timeout threshold still completes the access.
                if (mem.i_wb_ack) begin
                    cnt_d = '0;
                    if (store_q) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StExec;
                    end
                end else if (tmo_hit) begin
                    bus_err_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StExec: begin
                cnt_d = cnt_q + CW'(1);
                if (last_cnt) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            tmo_q      <= '0;
            store_q    <= 1'b0;
            size_q     <= 2'b00;
            lsb_q      <= 2'b00;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            store_q    <= store_d;
            size_q     <= size_d;
            lsb_q      <= lsb_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    always_comb begin
        sel = 4'b1111;
        unique case (size_q)
            2'b00:   sel = 4'b0001 << lsb_q;
            2'b01:   sel = lsb_q[1] ? 4'b1100 : 4'b0011;
            default: sel = 4'b1111;
        endcase
    end

    assign in_init = (state_q == StInit);
    assign in_bus  = (state_q == StBus);
    assign in_exec = (state_q == StExec);

    // Every output is derived from reset-cleared state, so reset silences them at once.
    assign mem.o_busy       = (state_q != StIdle);
    assign mem.o_init       = in_init;
    assign mem.o_en         = in_init | in_exec;
    assign mem.o_byte_valid = (in_init | in_exec) & in_range;
    assign mem.o_fill       = in_exec & ~in_range;
    assign mem.o_load       = in_bus & ~store_q & mem.i_wb_ack;
    assign mem.o_wb_cyc     = in_bus;
    assign mem.o_wb_we      = in_bus & store_q;
    assign mem.o_wb_sel     = in_bus ? sel : 4'b0000;
    assign mem.o_done       = done_q;
    assign mem.o_misalign   = misalign_q;
    assign mem.o_bus_err    = bus_err_q;
endmodule

// File: tb/tb_qerv_mem_seq.sv
// Bench for qerv_mem_seq: three instances (W=1/T=255, W=4/T=255, W=4/T=4); completion
// pulses are checked against a queue of expected events pushed when each request is issued.
module tb_qerv_mem_seq;
    localparam int KDone = 0;
    localparam int KMis  = 1;
    localparam int KErr  = 2;

    typedef struct {
        int g;
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] start_i, store_i, ack_i;
    logic [1:0] size_i [3];
    logic [1:0] lsb_i  [3];
    logic [2:0] busy_o, init_o, en_o, bv_o, fill_o, load_o, cyc_o, we_o, done_o, mis_o, err_o;
    logic [3:0] sel_o  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        qerv_mem_seq_if u_if ();
        assign u_if.i_start  = start_i[g];
        assign u_if.i_store  = store_i[g];
        assign u_if.i_size   = size_i[g];
        assign u_if.i_lsb    = lsb_i[g];
        assign u_if.i_wb_ack = ack_i[g];
        assign busy_o[g]     = u_if.o_busy;
        assign init_o[g]     = u_if.o_init;
        assign en_o[g]       = u_if.o_en;
        assign bv_o[g]       = u_if.o_byte_valid;
        assign fill_o[g]     = u_if.o_fill;
        assign load_o[g]     = u_if.o_load;
        assign cyc_o[g]      = u_if.o_wb_cyc;
        assign we_o[g]       = u_if.o_wb_we;
        assign sel_o[g]      = u_if.o_wb_sel;
        assign done_o[g]     = u_if.o_done;
        assign mis_o[g]      = u_if.o_misalign;
        assign err_o[g]      = u_if.o_bus_err;

        qerv_mem_seq #(
            .W      (g == 0 ? 1 : 4),
            .TIMEOUT(g == 2 ? 4 : 255)
        ) u_dut (
            .i_clk(clk),
            .i_rst(rst),
            .mem  (u_if)
        );
    end

    int          cyc_n = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          init_n [3];
    int          initv_n[3];
    int          hi_n   [3];
    int          load_n [3];
    int          exec_n [3];
    int          busy_n [3];
    logic [31:0] fill_v [3];
    logic [3:0]  sel_seen[3];
    logic        we_seen[3];
    ev_t         sb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: sample everything on the falling edge, return just after the rising edge.
    task automatic tick();
        ev_t e;
        int  kind;
        @(negedge clk);
        cyc_n++;
        for (int g = 0; g < 3; g++) begin
            if (busy_o[g]) busy_n[g]++;
            if (init_o[g]) begin
                init_n[g]++;
                if (bv_o[g]) initv_n[g]++;
            end
            if (en_o[g] && !init_o[g]) begin
                exec_n[g]++;
                fill_v[g] = {fill_v[g][30:0], fill_o[g]};
            end
            if (cyc_o[g]) begin
                hi_n[g]++;
                sel_seen[g] = sel_o[g];
                we_seen[g]  = we_o[g];
            end
            if (load_o[g]) load_n[g]++;
            if (done_o[g] || mis_o[g] || err_o[g]) begin
                kind = done_o[g] ? KDone : (mis_o[g] ? KMis : KErr);
                check_eq("pulse_onehot", 32'(int'(done_o[g]) + int'(mis_o[g]) + int'(err_o[g])), 1);
                if (sb_q.size() == 0) begin
                    check_eq($sformatf("pulse_none_due_g%0d", g), 32'(sb_q.size()), 1);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("pulse_inst", g, e.g);
                    check_eq("pulse_kind", kind, e.kind);
                    check_eq("pulse_cycle", cyc_n, e.cyc);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // waits = BUS cycles before the ack cycle; negative means no ack at all.
    task automatic run_op(input int g, input bit st, input logic [1:0] sz, input logic [1:0] lb,
                          input int waits, input bit noise);
        int          n, w, tmo, s, bus_s, ack_c, ev_c, end_c, noise_c, hi_exp, busy_exp;
        int          b_init, b_initv, b_hi, b_load, b_exec, b_busy;
        bit          mis, acked, word, half;
        logic [31:0] fill_exp, mask;
        logic [3:0]  sel_exp;
        ev_t         e;
        n     = (g == 0) ? 32 : 8;
        w     = (g == 0) ? 1 : 4;
        tmo   = (g == 2) ? 4 : 255;
        word  = sz[1];
        half  = (sz == 2'b01);
        mis   = (half && lb[0]) || (word && lb != 2'b00);
        s     = cyc_n + 1;
        bus_s = st ? s + n + 1 : s + 1;
        ack_c = (waits < 0) ? -1 : bus_s + waits;
        acked = !mis && waits >= 0 && waits < tmo;
        noise_c = -1;
        e.g = g;
        if (mis) begin
            ev_c = s + 1;  e.kind = KMis;  hi_exp = 0;
        end else if (acked) begin
            ev_c = st ? ack_c + 1 : ack_c + n + 1;  e.kind = KDone;  hi_exp = waits + 1;
            noise_c = st ? s + 2 : ack_c + 2;
        end else begin
            ev_c = bus_s + tmo;  e.kind = KErr;  hi_exp = tmo;
        end
        e.cyc = ev_c;
        sb_q.push_back(e);
        busy_exp = mis ? 0 : ev_c - s - 1;
        end_c = ((ack_c > ev_c) ? ack_c : ev_c) + 2;

        fill_exp = '0;
        for (int k = 0; k < n; k++) begin
            int bi;
            bi = (k * w) / 8;
            fill_exp = {fill_exp[30:0], !(word || bi == 0 || (half && bi < 2))};
        end
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        fill_exp = fill_exp & mask;
        if (sz == 2'b00) sel_exp = 4'b0001 << lb;
        else if (sz == 2'b01) sel_exp = lb[1] ? 4'b1100 : 4'b0011;
        else sel_exp = 4'b1111;

        b_init = init_n[g];  b_initv = initv_n[g];  b_hi = hi_n[g];
        b_load = load_n[g];  b_exec = exec_n[g];    b_busy = busy_n[g];

        start_i[g] = 1'b1;  store_i[g] = st;  size_i[g] = sz;  lsb_i[g] = lb;  ack_i[g] = 1'b0;
        tick();
        // Scramble the request fields: the sequencer must use its latched copies.
        start_i[g] = 1'b0;  store_i[g] = ~st;  size_i[g] = ~sz;  lsb_i[g] = ~lb;
        while (cyc_n < end_c) begin
            ack_i[g]   = (cyc_n + 1 == ack_c);
            start_i[g] = noise && (cyc_n + 1 == noise_c);
            tick();
        end
        ack_i[g] = 1'b0;
        start_i[g] = 1'b0;

        check_eq($sformatf("busy_cycles_g%0d", g), busy_n[g] - b_busy, busy_exp);
        check_eq($sformatf("init_cycles_g%0d", g), init_n[g] - b_init, (st && !mis) ? n : 0);
        check_eq($sformatf("init_valid_g%0d", g), initv_n[g] - b_initv,
                 (st && !mis) ? n - $countones(fill_exp) : 0);
        check_eq($sformatf("cyc_cycles_g%0d", g), hi_n[g] - b_hi, hi_exp);
        check_eq($sformatf("load_pulses_g%0d", g), load_n[g] - b_load, (acked && !st) ? 1 : 0);
        check_eq($sformatf("exec_cycles_g%0d", g), exec_n[g] - b_exec, (acked && !st) ? n : 0);
        if (acked && !st) check_eq($sformatf("fill_pattern_g%0d", g), fill_v[g] & mask, fill_exp);
        if (hi_exp > 0) begin
            check_eq($sformatf("wb_sel_g%0d", g), 32'(sel_seen[g]), 32'(sel_exp));
            check_eq($sformatf("wb_we_g%0d", g), 32'(we_seen[g]), 32'(st));
        end
        check_eq("sb_drained", 32'(sb_q.size()), 0);
        sb_q.delete();
    endtask

    task automatic reset_mid_bus();
        start_i[0] = 1'b1;  store_i[0] = 1'b0;  size_i[0] = 2'b10;  lsb_i[0] = 2'b00;
        tick();
        start_i[0] = 1'b0;
        check_eq("cyc_before_rst", 32'(cyc_o[0]), 1);
        #2 rst = 1'b1;
        #1;
        check_eq("cyc_async_rst", 32'(cyc_o[0]), 0);
        check_eq("busy_async_rst", 32'(busy_o[0]), 0);
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        start_i = '0;
        store_i = '0;
        ack_i   = '0;
        for (int g = 0; g < 3; g++) begin
            size_i[g] = 2'b00;
            lsb_i[g]  = 2'b00;
            fill_v[g] = '0;
            sel_seen[g] = '0;
            we_seen[g]  = 1'b0;
            init_n[g] = 0; initv_n[g] = 0; hi_n[g] = 0;
            load_n[g] = 0; exec_n[g] = 0;  busy_n[g] = 0;
        end
        #2;
        check_eq("rst_ctrl", 32'({busy_o, init_o, en_o, bv_o, fill_o, load_o, cyc_o}), 0);
        check_eq("rst_bus", 32'({we_o, done_o, mis_o, err_o, sel_o[0], sel_o[1], sel_o[2]}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_op(0, 1'b1, 2'b10, 2'd0, 0, 1'b0);   // store word, 34-cycle latency
        run_op(1, 1'b0, 2'b00, 2'd3, 5, 1'b0);   // load byte lsb=3, 5 wait cycles
        run_op(0, 1'b1, 2'b01, 2'd1, 0, 1'b0);   // misaligned store half
        run_op(0, 1'b0, 2'b10, 2'd2, 0, 1'b0);   // misaligned load word
        run_op(2, 1'b0, 2'b10, 2'd0, -1, 1'b0);  // timeout
        run_op(2, 1'b0, 2'b10, 2'd0, 3, 1'b0);   // ack on the threshold cycle
        run_op(2, 1'b1, 2'b00, 2'd1, 4, 1'b0);   // ack one cycle too late
        reset_mid_bus();
        run_op(0, 1'b0, 2'b10, 2'd0, 1, 1'b0);
        run_op(0, 1'b1, 2'b00, 2'd2, 1, 1'b1);   // stray start during INIT
        run_op(0, 1'b0, 2'b01, 2'd2, 0, 1'b1);   // stray start during EXEC
        run_op(1, 1'b0, 2'b11, 2'd0, 0, 1'b0);   // size 11 behaves as word
        run_op(1, 1'b1, 2'b01, 2'd2, 2, 1'b0);
        for (int i = 0; i < 12; i++) begin
            run_op(1 + int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/qerv_mem_seq.md
Name: qerv_mem_seq

Overview:
- Load/store sequencer for the W-bit-wide buffer/shift register in the qerv datapath.
- On a memory request it runs the register through three phases: an init phase that shifts store data into position, a Wishbone data-bus cycle, and an exec phase that shifts load data out toward rd.
- Generates the register's init/enable/byte-valid/load controls, the bus strobes and byte selects, misalignment traps and bus timeouts.
- Sits between the decode/state logic and the buffer register.

Parameters:
- W, 1, datapath width per cycle; legal values 1, 2, 4, 8. Defines N = 32/W cycles per phase.
- TIMEOUT, 255, bus cycles to wait for ack before error; 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_start  in  1  one-cycle request pulse; accepted only in IDLE
- i_store  in  1  1 = store, 0 = load
- i_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- i_lsb  in  2  address bits [1:0]
- o_busy  out  1  high in any state other than IDLE
- o_init  out  1  init phase active (drives register i_init)
- o_en  out  1  shift enable (drives register i_en)
- o_byte_valid  out  1  current byte lies within the access size (drives register i_byte_valid)
- o_fill  out  1  exec-phase bit is beyond the loaded size; rd takes the sign/zero fill
- o_load  out  1  latch bus data (drives register i_load)
- o_wb_cyc  out  1  bus cycle
- o_wb_we  out  1  write enable
- o_wb_sel  out  4  byte selects
- i_wb_ack  in  1  bus acknowledge
- o_done  out  1  one-cycle completion pulse
- o_misalign  out  1  one-cycle misaligned-access trap pulse
- o_bus_err  out  1  one-cycle timeout pulse

Behaviour:
- Reset is asynchronous and active-high. Reset forces IDLE, clears cnt and the timeout counter, and drives every output to 0 immediately, including o_wb_cyc mid-transaction.
- States: IDLE, INIT, BUS, EXEC.
- Counter cnt is log2(N) bits wide. Byte index bi = (cnt*W)>>3.
- o_byte_valid = (size==word) | (bi==0) | (size==half & bi<2).
- Misalignment is defined as (half & i_lsb[0]) | (word & i_lsb!=0).
- IDLE, on i_start:
  - If misaligned: assert o_misalign in the next cycle, stay IDLE, no bus activity.
  - Else if store: go to INIT with cnt=0.
  - Else (load): go to BUS.
  - i_start in any other state is ignored.
- INIT (stores only):
  - o_init=1, o_en=1 for exactly N cycles.
  - cnt increments and wraps to 0 on the Nth cycle; the state then moves to BUS.
- BUS:
  - o_wb_cyc=1 from the first BUS cycle until the ack cycle inclusive; o_wb_we=i_store (latched at start).
  - o_wb_sel: byte = 4'b0001<<lsb; half = lsb[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
  - On i_wb_ack:
    - Load: o_load=1 in the same cycle, next state EXEC with cnt=0.
    - Store: o_done=1 in the next cycle, return to IDLE.
  - i_wb_ack is ignored outside BUS.
  - Timeout counter increments each BUS cycle without ack. On reaching TIMEOUT: drop o_wb_cyc, pulse o_bus_err the next cycle, return to IDLE, no o_done.
  - Ack arriving in the same cycle as the timeout threshold wins: the access completes normally.
- EXEC (loads only):
  - o_en=1 for N cycles.
  - o_fill = !o_byte_valid (so byte loads fill from bit 8 and halfword loads from bit 16).
  - After cnt wraps: o_done=1 in the next cycle, state IDLE.
- Latency with no bus wait states (ack on the first BUS cycle):
  - Store: N + 2 cycles from i_start to o_done.
  - Load: N + 2 cycles from i_start to o_done.
- i_size, i_lsb and i_store are latched at start. Changes to them mid-operation have no effect.
- o_done, o_misalign and o_bus_err are mutually exclusive and last exactly one cycle.

Test Plan:
- W=1, store word, lsb=0, ack on the 1st BUS cycle:
  - o_init high 32 cycles.
  - o_wb_sel=1111, o_wb_we=1.
  - o_done 34 cycles after i_start.
- W=4, load byte, lsb=3, ack after 5 wait cycles:
  - o_wb_sel=1000.
  - o_load pulses in the ack cycle.
  - EXEC lasts 8 cycles with o_fill=1 on cnt 2..7.
  - o_done follows.
- Store half with lsb=1, and load word with lsb=2:
  - o_misalign pulses, o_wb_cyc never rises, o_busy stays 0.
- TIMEOUT=4, no ack:
  - o_wb_cyc high 4 cycles, then o_bus_err pulses and the block is back in IDLE.
  - Repeat with ack exactly on cycle 4: o_done, no error.
- Reset mid-BUS:
  - Assert i_rst asynchronously: o_wb_cyc falls without a clock edge.
  - After release, a new i_start runs a normal load.
- i_start pulsed during INIT and EXEC:
  - Ignored; exactly one o_done per accepted request.
